// File: rtl/seq_subtractor.sv
// Bit-serial unsigned subtractor: processes one bit per clock, LSB first, and
// reports (a - b) mod 2^WIDTH plus the final borrow after WIDTH+1 cycles.
module seq_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             br_q, br_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             d_bit;
    logic             br_next;
    logic [WIDTH:0]   res_ext;
    logic [WIDTH-1:0] res_shift;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            br_q     <= 1'b0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            br_q     <= br_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
        end
    end

    // Full-subtractor cell on the current LSBs; the new bit enters at the MSB.
    always_comb begin
        d_bit     = a_q[0] ^ b_q[0] ^ br_q;
        br_next   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
        res_ext   = {d_bit, res_q};
        res_shift = res_ext[WIDTH:1];
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        diff_d   = diff_q;
        br_d     = br_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    res_d   = '0;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = br_next;
                res_d = res_shift;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    diff_d   = res_shift;
                    borrow_d = br_next;
                    cnt_d    = '0;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy   = (state_q == SHIFT);
    assign done   = (state_q == DONE);
    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule

// File: doc/seq_subtractor.md
SEQ_SUBTRACTOR -- requirements
Module: seq_subtractor

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; all widths below are in terms of WIDTH.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 a  input  WIDTH  minuend, unsigned; captured when start is accepted.
REQ-006 b  input  WIDTH  subtrahend, unsigned; captured when start is accepted.
REQ-007 busy  output  1  high while a subtraction is in progress.
REQ-008 done  output  1  single-cycle pulse marking diff and borrow valid.
REQ-009 diff  output  WIDTH  result, (a - b) mod 2^WIDTH.
REQ-010 borrow  output  1  final borrow: 1 iff a < b (unsigned).

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-012 In IDLE with start=1 at edge k, the block SHALL capture a and b into internal shift registers, clear the running borrow, clear a bit counter, and enter SHIFT.
REQ-013 In SHIFT, each edge SHALL process one bit, LSB first: d = a0 ^ b0 ^ br; br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
REQ-014 In SHIFT, each edge SHALL shift d into the MSB end of the result register, so that after WIDTH bits the result is bit-aligned with diff[WIDTH-1:0].
REQ-015 The bit counter SHALL count 0..WIDTH-1; SHIFT SHALL last exactly WIDTH cycles and then transition to DONE.
REQ-016 busy SHALL be 1 in cycles k+1 through k+WIDTH (SHIFT) and 0 otherwise.
REQ-017 done SHALL be 1 for exactly one cycle, k+WIDTH+1 (DONE state), so the latency from start to done is WIDTH+1 cycles.
REQ-018 DONE SHALL unconditionally return to IDLE on the next edge.
REQ-019 diff and borrow SHALL update only on entry to DONE.
REQ-020 diff and borrow SHALL hold their values until the next entry to DONE or until reset.
REQ-021 diff and borrow SHALL NOT change during SHIFT; intermediate bits are kept internal.
REQ-022 start SHALL be ignored in SHIFT and DONE; the earliest next accepted start is the first cycle back in IDLE.
REQ-023 Changes on a and b after capture SHALL NOT affect the result in progress.
REQ-024 Arithmetic is modulo 2^WIDTH with no saturation.
REQ-025 Wrap-around SHALL be reported solely through borrow.
REQ-026 A held-high start SHALL launch a new operation on every return to IDLE, i.e. back-to-back operations every WIDTH+2 cycles.

Reset
REQ-027 While reset=1, the state SHALL be IDLE and busy, done, diff, borrow and all internal registers SHALL be 0, independent of clk.
REQ-028 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse.
REQ-029 Reset asserted in DONE SHALL clear done in the same cycle.
REQ-030 After reset deasserts, the first rising edge SHALL be treated as IDLE.
REQ-031 start sampled on that first edge after reset release SHALL be accepted normally.

Verification
REQ-032 WIDTH=8, a=120, b=20, one-cycle start -> busy high for 8 cycles; done pulses at cycle 9; diff=100, borrow=0.
REQ-033 a=20, b=100 -> diff=176, borrow=1.
REQ-034 a=0, b=1 -> diff=255, borrow=1.
REQ-035 a=255, b=255 -> diff=0, borrow=0.
REQ-036 Start with a=50, b=5; pulse start again and change a to 7 during SHIFT -> exactly one done, diff=45.
REQ-037 Start a=200, b=100; assert reset at cycle 4 -> busy, diff and borrow go to 0 immediately and no done pulse follows.
REQ-038 After the reset in REQ-037, a new start with a=9, b=3 -> diff=6 after WIDTH+1 cycles.
REQ-039 start held high for 30 cycles with a=10, b=3 -> done pulses every 10 cycles, diff=7 each time.
